inst_sram_responder: RTL and testbench



---
 rtl/inst_sram_responder.sv | 83 ++++++++
 tb/tb_inst_sram_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/inst_sram_responder.sv
// Single-port instruction/data SRAM responder: one access per cycle, registered
// read-first data held across stalls, backdoor load port, sticky range error and access counters.
module inst_sram_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h1c000000,
  parameter int unsigned DEPTH_LOG2 = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  sram_en,
  input  logic [3:0]            sram_we,
  input  logic [31:0]           sram_addr,
  input  logic [31:0]           sram_wdata,
  output logic [31:0]           sram_rdata,
  output logic                  sram_err,
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wr_cnt,
  input  logic                  bd_we,
  input  logic [DEPTH_LOG2-1:0] bd_idx,
  input  logic [31:0]           bd_wdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  // Byte span of the array, one bit wider so large depths cannot overflow.
  localparam logic [32:0] SPAN  = 33'd4 << DEPTH_LOG2;

  logic [31:0]           mem_r [DEPTH];
  logic [31:0]           off_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic                  in_range_s;
  logic                  rd_hit_s;
  logic                  wr_hit_s;
  logic                  bad_s;

  // Address decode and access classification.
  always_comb begin
    off_s      = sram_addr - BASE_ADDR;
    idx_s      = off_s[DEPTH_LOG2+1:2];
    in_range_s = (sram_addr >= BASE_ADDR) && ({1'b0, off_s} < SPAN);
    rd_hit_s   = sram_en && (sram_we == 4'b0000) && in_range_s;
    wr_hit_s   = sram_en && (sram_we != 4'b0000) && in_range_s;
    bad_s      = sram_en && !in_range_s;
  end

  // Storage array; front-port lanes are applied after the backdoor word so they win a collision.
  always_ff @(posedge clk) begin
    if (bd_we) begin
      mem_r[bd_idx] <= bd_wdata;
    end
    if (wr_hit_s) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_we[i]) begin
          mem_r[idx_s][8*i +: 8] <= sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read data register, sticky error flag and access counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sram_rdata <= 32'h0;
      sram_err   <= 1'b0;
      rd_cnt     <= 32'h0;
      wr_cnt     <= 32'h0;
    end else begin
      if (rd_hit_s || wr_hit_s) begin
        sram_rdata <= mem_r[idx_s];
      end else if (bad_s) begin
        sram_rdata <= 32'h0;
      end
      if (bad_s) begin
        sram_err <= 1'b1;
      end
      if (rd_hit_s) begin
        rd_cnt <= rd_cnt + 32'd1;
      end
      if (wr_hit_s) begin
        wr_cnt <= wr_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_inst_sram_responder.sv
// Directed self-checking bench for inst_sram_responder with hand-computed expectations.
module tb_inst_sram_responder;

  logic        clk;
  logic        resetn;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic        bd_we;
  logic [15:0] bd_idx;
  logic [31:0] bd_wdata;

  int total;
  int bad;

  inst_sram_responder dut (
    .clk        (clk),
    .resetn     (resetn),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_err   (sram_err),
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt),
    .bd_we      (bd_we),
    .bd_idx     (bd_idx),
    .bd_wdata   (bd_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdata);
    sram_en    = 1'b1;
    sram_addr  = addr;
    sram_we    = we;
    sram_wdata = wdata;
    tick();
    sram_en    = 1'b0;
    sram_we    = 4'b0000;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    resetn     = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 4'b0000;
    sram_addr  = 32'h0;
    sram_wdata = 32'h0;
    bd_we      = 1'b0;
    bd_idx     = 16'd0;
    bd_wdata   = 32'h0;

    #12;
    check_eq("rst_rdata", sram_rdata, 32'h0);
    check_eq("rst_err", {31'd0, sram_err}, 32'h0);
    check_eq("rst_rdcnt", rd_cnt, 32'h0);
    check_eq("rst_wrcnt", wr_cnt, 32'h0);
    resetn = 1'b1;
    tick();

    // Backdoor load words 0..3
    for (int i = 0; i < 4; i++) begin
      bd_we    = 1'b1;
      bd_idx   = 16'(i);
      bd_wdata = 32'h11111111 * 32'(i + 1);
      tick();
    end
    bd_we = 1'b0;
    check_eq("bd_no_rdata", sram_rdata, 32'h0);

    // Fetch stream
    access(32'h1c000000, 4'b0000, 32'h0);
    check_eq("fetch0", sram_rdata, 32'h11111111);
    access(32'h1c000004, 4'b0000, 32'h0);
    check_eq("fetch1", sram_rdata, 32'h22222222);
    access(32'h1c000008, 4'b0000, 32'h0);
    check_eq("fetch2", sram_rdata, 32'h33333333);
    check_eq("fetch_rdcnt", rd_cnt, 32'd3);

    // Stall hold, with toggling address and write enables while en is low
    access(32'h1c00000c, 4'b0000, 32'h0);
    check_eq("stall_first", sram_rdata, 32'h44444444);
    for (int i = 0; i < 5; i++) begin
      sram_en    = 1'b0;
      sram_we    = 4'b1111;
      sram_wdata = 32'hdeadbeef;
      sram_addr  = (i % 2 == 0) ? 32'h1c000000 : 32'h1c000004;
      tick();
      check_eq("stall_hold", sram_rdata, 32'h44444444);
    end
    sram_we = 4'b0000;
    check_eq("stall_rdcnt", rd_cnt, 32'd4);
    check_eq("stall_wrcnt", wr_cnt, 32'd0);

    // Byte write, read-first
    access(32'h1c000000, 4'b0101, 32'haabbccdd);
    check_eq("bw_readfirst", sram_rdata, 32'h11111111);
    check_eq("bw_wrcnt", wr_cnt, 32'd1);
    access(32'h1c000000, 4'b0000, 32'h0);
    check_eq("bw_readback", sram_rdata, 32'h11bb11dd);
    check_eq("bw_rdcnt", rd_cnt, 32'd5);

    // Out of range: below base, then one past the end
    access(32'h1bfffffc, 4'b0000, 32'h0);
    check_eq("oor_rd_data", sram_rdata, 32'h0);
    check_eq("oor_rd_err", {31'd0, sram_err}, 32'd1);
    check_eq("oor_rd_cnt", rd_cnt, 32'd5);
    access(32'h1c040000, 4'b1111, 32'hcafef00d);
    check_eq("oor_wr_err", {31'd0, sram_err}, 32'd1);
    check_eq("oor_wr_cnt", wr_cnt, 32'd1);
    access(32'h1c000004, 4'b0000, 32'h0);
    check_eq("oor_after_rd", sram_rdata, 32'h22222222);
    check_eq("err_sticky", {31'd0, sram_err}, 32'd1);
    access(32'h1c000000, 4'b0000, 32'h0);
    check_eq("oor_no_write", sram_rdata, 32'h11bb11dd);
    check_eq("oor_rdcnt", rd_cnt, 32'd7);

    // Last in-range word
    access(32'h1c03fffc, 4'b1111, 32'h12345678);
    access(32'h1c03fffc, 4'b0000, 32'h0);
    check_eq("last_word", sram_rdata, 32'h12345678);
    check_eq("last_wrcnt", wr_cnt, 32'd2);

    // Collision: backdoor and front write to the same index
    bd_we    = 1'b1;
    bd_idx   = 16'd2;
    bd_wdata = 32'hffffffff;
    access(32'h1c000008, 4'b0011, 32'h00000000);
    bd_we = 1'b0;
    check_eq("coll_wr_old", sram_rdata, 32'h33333333);
    access(32'h1c000008, 4'b0000, 32'h0);
    check_eq("coll_wr_merge", sram_rdata, 32'hffff0000);

    // Collision: backdoor write against front read returns old word
    bd_we    = 1'b1;
    bd_idx   = 16'd3;
    bd_wdata = 32'h55555555;
    access(32'h1c00000c, 4'b0000, 32'h0);
    bd_we = 1'b0;
    check_eq("coll_rd_old", sram_rdata, 32'h44444444);
    access(32'h1c00000c, 4'b0000, 32'h0);
    check_eq("coll_rd_new", sram_rdata, 32'h55555555);

    // Reset in the middle of a read burst
    access(32'h1c000000, 4'b0000, 32'h0);
    sram_en   = 1'b1;
    sram_addr = 32'h1c000004;
    #3;
    resetn = 1'b0;
    #1;
    check_eq("mrst_rdata", sram_rdata, 32'h0);
    check_eq("mrst_err", {31'd0, sram_err}, 32'h0);
    check_eq("mrst_rdcnt", rd_cnt, 32'h0);
    check_eq("mrst_wrcnt", wr_cnt, 32'h0);
    tick();
    check_eq("mrst_held", sram_rdata, 32'h0);
    #3;
    resetn = 1'b1;
    tick();
    sram_en = 1'b0;
    check_eq("post_rst_rd", sram_rdata, 32'h22222222);
    check_eq("post_rst_cnt", rd_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
